// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin arbiter sharing one register-file write port
// among NUM_REQ write-back requesters. The winning write is registered and
// presented on we_o/wa_o/wd_o one cycle after acceptance. Writes to x0 can be
// suppressed, and committed writes are counted modulo 2^CNT_W.
module rf_write_arbiter #(
  parameter int unsigned NUM_REQ          = 3,
  parameter bit          ZERO_REG_PROTECT = 1'b1,
  parameter int unsigned CNT_W            = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    hold_i,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*5-1:0]    req_addr,
  input  logic [NUM_REQ*32-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    we_o,
  output logic [4:0]              wa_o,
  output logic [31:0]             wd_o,
  output logic                    busy_o,
  output logic [CNT_W-1:0]        wr_cnt_o
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             we_q, we_d;
  logic [4:0]       wa_q, wa_d;
  logic [31:0]      wd_q, wd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             gnt_vld;
  logic [PTR_W-1:0] gnt_idx;
  logic [4:0]       sel_addr;
  logic [31:0]      sel_data;

  // Round-robin search starting at rr_ptr; grants are suppressed in reset and on hold.
  always_comb begin
    int unsigned idx;
    logic [PTR_W-1:0] cand;
    gnt_vld   = 1'b0;
    gnt_idx   = '0;
    req_ready = '0;
    idx       = 0;
    cand      = '0;
    if (rst && !hold_i) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        idx = 32'(rr_ptr_q) + k;
        if (idx >= NUM_REQ) begin
          idx = idx - NUM_REQ;
        end
        cand = PTR_W'(idx);
        if (!gnt_vld && req_valid[cand]) begin
          gnt_vld = 1'b1;
          gnt_idx = cand;
        end
      end
      if (gnt_vld) begin
        req_ready[gnt_idx] = 1'b1;
      end
    end
  end

  // Select the granted requester's address and data.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == PTR_W'(i)) begin
        sel_addr = req_addr[i*5 +: 5];
        sel_data = req_data[i*32 +: 32];
      end
    end
  end

  // Requests left waiting this cycle.
  always_comb begin
    busy_o = |(req_valid & ~req_ready);
  end

  // Next-state: capture the winning write, advance pointer past winner, count commits.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    we_d     = 1'b0;
    wa_d     = wa_q;
    wd_d     = wd_q;
    cnt_d    = we_q ? cnt_q + CNT_W'(1) : cnt_q;
    // req_ready is only set on a valid index, so a grant is always a transfer.
    if (gnt_vld) begin
      wa_d     = sel_addr;
      wd_d     = sel_data;
      we_d     = !(ZERO_REG_PROTECT && (sel_addr == 5'd0));
      rr_ptr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end
  end

  // State registers; reset discards any pending registered write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q <= '0;
      we_q     <= 1'b0;
      wa_q     <= '0;
      wd_q     <= '0;
      cnt_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      we_q     <= we_d;
      wa_q     <= wa_d;
      wd_q     <= wd_d;
      cnt_q    <= cnt_d;
    end
  end

  assign we_o     = we_q;
  assign wa_o     = wa_q;
  assign wd_o     = wd_q;
  assign wr_cnt_o = cnt_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Testbench for rf_write_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural model of the round-robin write port.
module tb_rf_write_arbiter;

  logic        clk;
  logic        rst;
  logic        hold;
  logic [2:0]  valid;
  logic [14:0] addr;
  logic [95:0] data;

  logic [2:0]  ready_p, ready_n, ready_w;
  logic        we_p, we_n, we_w;
  logic [4:0]  wa_p, wa_n, wa_w;
  logic [31:0] wd_p, wd_n, wd_w;
  logic        busy_p, busy_n, busy_w;
  logic [15:0] cnt_p, cnt_n;
  logic [3:0]  cnt_w;

  int n_checks;
  int n_fail;

  // behavioural model state
  int          m_ptr;
  bit          m_we_p, m_we_n;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  int unsigned m_cnt16, m_cnt4, m_cnt_n;
  int          last_gnt;

  rf_write_arbiter #(.NUM_REQ(3), .ZERO_REG_PROTECT(1'b1), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .hold_i(hold), .req_valid(valid), .req_addr(addr),
    .req_data(data), .req_ready(ready_p), .we_o(we_p), .wa_o(wa_p), .wd_o(wd_p),
    .busy_o(busy_p), .wr_cnt_o(cnt_p));

  rf_write_arbiter #(.NUM_REQ(3), .ZERO_REG_PROTECT(1'b0), .CNT_W(16)) u_nz (
    .clk(clk), .rst(rst), .hold_i(hold), .req_valid(valid), .req_addr(addr),
    .req_data(data), .req_ready(ready_n), .we_o(we_n), .wa_o(wa_n), .wd_o(wd_n),
    .busy_o(busy_n), .wr_cnt_o(cnt_n));

  rf_write_arbiter #(.NUM_REQ(3), .ZERO_REG_PROTECT(1'b1), .CNT_W(4)) u_w4 (
    .clk(clk), .rst(rst), .hold_i(hold), .req_valid(valid), .req_addr(addr),
    .req_data(data), .req_ready(ready_w), .we_o(we_w), .wa_o(wa_w), .wd_o(wd_w),
    .busy_o(busy_w), .wr_cnt_o(cnt_w));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_gnt();
    if (rst !== 1'b1 || hold !== 1'b0 || valid == 3'b000) return -1;
    for (int k = 0; k < 3; k++) begin
      int idx;
      idx = (m_ptr + k) % 3;
      if (valid[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [2:0] exp_ready();
    int g;
    g = exp_gnt();
    if (g < 0) return 3'b000;
    return 3'b001 << g;
  endfunction

  function automatic logic [4:0] rand_addr();
    if ($urandom_range(0, 5) == 0) return 5'd0;
    return 5'($urandom_range(1, 31));
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_we_p = 0; m_we_n = 0; m_wa = '0; m_wd = '0;
    m_cnt16 = 0; m_cnt4 = 0; m_cnt_n = 0; last_gnt = -1;
  endtask

  // Advance one clock edge and update the model with what that edge commits.
  task automatic tick();
    int g;
    logic [4:0] a;
    g = exp_gnt();
    @(posedge clk);
    if (m_we_p) begin
      m_cnt16 = (m_cnt16 + 1) % 65536;
      m_cnt4  = (m_cnt4 + 1) % 16;
    end
    if (m_we_n) m_cnt_n = (m_cnt_n + 1) % 65536;
    if (g >= 0) begin
      a = addr[g*5 +: 5];
      m_wa = a;
      m_wd = data[g*32 +: 32];
      m_we_p = (a != 5'd0);
      m_we_n = 1'b1;
      m_ptr = (g + 1) % 3;
    end else begin
      m_we_p = 0;
      m_we_n = 0;
    end
    last_gnt = g;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; valid = '0; hold = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    valid = 3'b111;
    for (int i = 0; i < 3; i++) begin
      addr[i*5 +: 5] = 5'(i + 3);
      data[i*32 +: 32] = $urandom;
    end
    #1;
    n_checks++;
    if (ready_p !== 3'b000) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 000", ready_p);
    end
    n_checks++;
    if ({we_p, wa_p, wd_p, cnt_p} !== 54'd0) begin
      n_fail++; $display("FAIL reset_outputs: got we=%b wa=%0d wd=%h cnt=%0d expected all 0", we_p, wa_p, wd_p, cnt_p);
    end
    model_reset();
    rst = 1'b1;
    tick(); tick(); tick();
    n_checks++;
    if (we_p !== 1'b1 || cnt_p !== 16'd2) begin
      n_fail++; $display("FAIL pre_reset_stream: got we=%b cnt=%0d expected we=1 cnt=2", we_p, cnt_p);
    end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({we_p, wa_p, wd_p, cnt_p} !== 54'd0) begin
      n_fail++; $display("FAIL midstream_reset: got we=%b wa=%0d wd=%h cnt=%0d expected all 0", we_p, wa_p, wd_p, cnt_p);
    end
    n_checks++;
    if (ready_p !== 3'b000) begin
      n_fail++; $display("FAIL midstream_reset_ready: got %b expected 000", ready_p);
    end
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b1;
    valid = 3'b110;
    #1;
    n_checks++;
    if (ready_p !== 3'b010) begin
      n_fail++; $display("FAIL first_grant_after_reset: got %b expected 010", ready_p);
    end
  endtask

  task automatic test_single_write();
    do_reset();
    valid = 3'b010;
    addr[5 +: 5] = 5'd5;
    data[32 +: 32] = 32'hDEADBEEF;
    #1;
    n_checks++;
    if (ready_p !== 3'b010) begin
      n_fail++; $display("FAIL single_ready: got %b expected 010", ready_p);
    end
    tick();
    valid = 3'b000;
    #1;
    n_checks++;
    if ({we_p, wa_p, wd_p} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL single_write: got we=%b wa=%0d wd=%h expected we=1 wa=5 wd=deadbeef", we_p, wa_p, wd_p);
    end
    tick();
    n_checks++;
    if (cnt_p !== 16'd1 || we_p !== 1'b0) begin
      n_fail++; $display("FAIL single_count: got cnt=%0d we=%b expected cnt=1 we=0", cnt_p, we_p);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      addr[i*5 +: 5] = 5'(10 + i);
      data[i*32 +: 32] = $urandom;
    end
    valid = 3'b111;
    #1;
    for (int c = 0; c < 6; c++) begin
      logic [2:0] er;
      int prev;
      er = 3'b001 << (c % 3);
      n_checks++;
      if (ready_p !== er || busy_p !== 1'b1) begin
        n_fail++; $display("FAIL b2b_grant[%0d]: got ready=%b busy=%b expected ready=%b busy=1", c, ready_p, busy_p, er);
      end
      if (c > 0) begin
        prev = (c - 1) % 3;
        n_checks++;
        if (we_p !== 1'b1 || wa_p !== addr[prev*5 +: 5] || wd_p !== data[prev*32 +: 32]) begin
          n_fail++; $display("FAIL b2b_write[%0d]: got we=%b wa=%0d expected we=1 wa=%0d", c, we_p, wa_p, addr[prev*5 +: 5]);
        end
      end
      tick();
    end
    n_checks++;
    if (cnt_p !== 16'd5) begin
      n_fail++; $display("FAIL b2b_count: got %0d expected 5", cnt_p);
    end
  endtask

  task automatic test_zero_addr();
    do_reset();
    valid = 3'b001;
    addr[0 +: 5] = 5'd0;
    data[0 +: 32] = 32'h12345678;
    #1;
    n_checks++;
    if (ready_p !== 3'b001) begin
      n_fail++; $display("FAIL zero_ready: got %b expected 001", ready_p);
    end
    tick();
    valid = 3'b000;
    #1;
    n_checks++;
    if (we_p !== 1'b0) begin
      n_fail++; $display("FAIL zero_protected_we: got %b expected 0", we_p);
    end
    n_checks++;
    if (we_n !== 1'b1 || wa_n !== 5'd0 || wd_n !== 32'h12345678) begin
      n_fail++; $display("FAIL zero_unprotected: got we=%b wa=%0d wd=%h expected we=1 wa=0 wd=12345678", we_n, wa_n, wd_n);
    end
    tick();
    n_checks++;
    if (cnt_p !== 16'd0 || cnt_n !== 16'd1) begin
      n_fail++; $display("FAIL zero_count: got prot=%0d unprot=%0d expected prot=0 unprot=1", cnt_p, cnt_n);
    end
  endtask

  task automatic test_stall();
    do_reset();
    valid = 3'b001;
    addr[0 +: 5] = 5'd7;
    data[0 +: 32] = 32'hA5A5A5A5;
    addr[10 +: 5] = 5'd9;
    data[64 +: 32] = 32'h0BADF00D;
    tick();
    valid = 3'b100;
    hold = 1'b1;
    #1;
    n_checks++;
    if (we_p !== 1'b1 || wa_p !== 5'd7 || ready_p !== 3'b000) begin
      n_fail++; $display("FAIL hold_commit: got we=%b wa=%0d ready=%b expected we=1 wa=7 ready=000", we_p, wa_p, ready_p);
    end
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (ready_p !== 3'b000 || busy_p !== 1'b1) begin
        n_fail++; $display("FAIL stall[%0d]: got ready=%b busy=%b expected ready=000 busy=1", c, ready_p, busy_p);
      end
      tick();
      n_checks++;
      if (we_p !== 1'b0) begin
        n_fail++; $display("FAIL stall_we[%0d]: got %b expected 0", c, we_p);
      end
    end
    n_checks++;
    if (cnt_p !== 16'd1) begin
      n_fail++; $display("FAIL stall_count: got %0d expected 1", cnt_p);
    end
    hold = 1'b0;
    #1;
    n_checks++;
    if (ready_p !== 3'b100 || busy_p !== 1'b0) begin
      n_fail++; $display("FAIL stall_release: got ready=%b busy=%b expected ready=100 busy=0", ready_p, busy_p);
    end
    tick();
    valid = 3'b111;
    #1;
    n_checks++;
    if (ready_p !== 3'b001 || we_p !== 1'b1 || wd_p !== 32'h0BADF00D) begin
      n_fail++; $display("FAIL stall_ptr: got ready=%b we=%b wd=%h expected ready=001 we=1 wd=0badf00d", ready_p, we_p, wd_p);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    valid = 3'b001;
    addr[0 +: 5] = 5'd3;
    for (int i = 0; i < 17; i++) begin
      data[0 +: 32] = $urandom;
      tick();
    end
    n_checks++;
    if (cnt_w !== 4'd0 || cnt_p !== 16'd16) begin
      n_fail++; $display("FAIL wrap16: got w4=%0d w16=%0d expected w4=0 w16=16", cnt_w, cnt_p);
    end
    valid = 3'b000;
    tick();
    n_checks++;
    if (cnt_w !== 4'd1 || cnt_p !== 16'd17) begin
      n_fail++; $display("FAIL wrap17: got w4=%0d w16=%0d expected w4=1 w16=17", cnt_w, cnt_p);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      addr[i*5 +: 5] = rand_addr();
      data[i*32 +: 32] = $urandom;
    end
    valid = 3'($urandom_range(0, 7));
    #1;
    for (int c = 0; c < 400; c++) begin
      logic [2:0] er;
      er = exp_ready();
      n_checks++;
      if (ready_p !== er || ready_n !== er || ready_w !== er) begin
        n_fail++; $display("FAIL rnd_ready[%0d]: got %b/%b/%b expected %b", c, ready_p, ready_n, ready_w, er);
      end
      n_checks++;
      if (busy_p !== |(valid & ~er)) begin
        n_fail++; $display("FAIL rnd_busy[%0d]: got %b expected %b", c, busy_p, |(valid & ~er));
      end
      n_checks++;
      if ({we_p, wa_p, wd_p} !== {m_we_p, m_wa, m_wd} || we_n !== m_we_n) begin
        n_fail++; $display("FAIL rnd_write[%0d]: got we=%b/%b wa=%0d wd=%h expected we=%b/%b wa=%0d wd=%h",
                           c, we_p, we_n, wa_p, wd_p, m_we_p, m_we_n, m_wa, m_wd);
      end
      n_checks++;
      if (cnt_p !== 16'(m_cnt16) || cnt_w !== 4'(m_cnt4) || cnt_n !== 16'(m_cnt_n)) begin
        n_fail++; $display("FAIL rnd_count[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d",
                           c, cnt_p, cnt_w, cnt_n, m_cnt16, m_cnt4, m_cnt_n);
      end
      tick();
      for (int i = 0; i < 3; i++) begin
        bit newreq;
        newreq = 0;
        if (last_gnt == i) begin
          valid[i] = 1'b0;
          newreq = ($urandom_range(0, 1) == 1);
        end else if (valid[i]) begin
          if ($urandom_range(0, 7) == 0) valid[i] = 1'b0;
        end else begin
          newreq = ($urandom_range(0, 1) == 1);
        end
        if (newreq) begin
          valid[i] = 1'b1;
          addr[i*5 +: 5] = rand_addr();
          data[i*32 +: 32] = $urandom;
        end
      end
      hold = ($urandom_range(0, 5) == 0);
      #1;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b0;
    hold = 1'b0;
    valid = '0;
    addr = '0;
    data = '0;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_single_write();
    test_back_to_back();
    test_zero_addr();
    test_stall();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
